// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: time-multiplexed 7-segment scan controller.
// Steps a digit index through DIGITS slots of PRESCALE cycles each. Every
// slot starts with BLANK dark cycles to stop ghosting between digits.
// Host data is written into a pending buffer. That buffer is copied into the
// active buffer only at a frame wrap, so a frame is never shown half old and
// half new.
// Optional: define DISPLAY_SCAN_LZB_EN to add leading-zero blanking.
module display_scan_ctrl #(
   parameter int DIGITS   = 4,
   parameter int PRESCALE = 1000,
   parameter int BLANK    = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  run,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   data_in,
   input  logic [DIGITS-1:0]     dp_in,
   input  logic [DIGITS-1:0]     en_in,
   output logic [3:0]            nib_out,
   output logic                  dp_out,
   output logic [DIGITS-1:0]     dig_sel_n,
   output logic                  frame_done
);

   localparam int CW = $clog2(PRESCALE);
   localparam int IW = $clog2(DIGITS);

   logic [CW-1:0]          cnt_q, cnt_d;
   logic [IW-1:0]          idx_q, idx_d;
   logic                   tick, wrap;

   logic [4*DIGITS-1:0]    pend_data_q, pend_data_d;
   logic [DIGITS-1:0]      pend_dp_q, pend_dp_d;
   logic [DIGITS-1:0]      pend_en_q, pend_en_d;
   logic                   pend_valid_q, pend_valid_d;

   logic [4*DIGITS-1:0]    act_data_q, act_data_d;
   logic [DIGITS-1:0]      act_dp_q, act_dp_d;
   logic [DIGITS-1:0]      act_en_q, act_en_d;
   logic                   act_upd;
   logic [DIGITS-1:0][3:0] act_nib;

   logic [3:0]             nib_q, nib_d;
   logic                   dp_q, dp_d;
   logic [DIGITS-1:0]      sel_n_q, sel_n_d;
   logic                   fd_q, fd_d;
   logic [DIGITS-1:0]      vis;

   assign act_nib = act_data_q;

   // Prescaler and digit index: both hold while run is low
   always_comb begin
      tick  = run && (cnt_q == CW'(PRESCALE - 1));
      wrap  = tick && (idx_q == IW'(DIGITS - 1));
      cnt_d = cnt_q;
      idx_d = idx_q;
      if (run) begin
         cnt_d = tick ? '0 : cnt_q + CW'(1);
      end
      if (tick) begin
         idx_d = wrap ? '0 : idx_q + IW'(1);
      end
   end

   // Double buffer: load fills pending; only a wrap moves data into active.
   // A load on the wrap cycle goes straight to active.
   always_comb begin
      pend_data_d  = pend_data_q;
      pend_dp_d    = pend_dp_q;
      pend_en_d    = pend_en_q;
      pend_valid_d = pend_valid_q;
      act_data_d   = act_data_q;
      act_dp_d     = act_dp_q;
      act_en_d     = act_en_q;
      act_upd      = wrap && (load || pend_valid_q);
      if (load) begin
         pend_data_d  = data_in;
         pend_dp_d    = dp_in;
         pend_en_d    = en_in;
         pend_valid_d = 1'b1;
      end
      if (act_upd) begin
         act_data_d   = load ? data_in : pend_data_q;
         act_dp_d     = load ? dp_in   : pend_dp_q;
         act_en_d     = load ? en_in   : pend_en_q;
         pend_valid_d = 1'b0;
      end
   end

`ifdef DISPLAY_SCAN_LZB_EN
   logic [DIGITS-1:0] keep_q, keep_d;

   // Keep digit 0, any digit with dp set, and every digit at or below the
   // most significant nonzero digit
   always_comb begin : p_keep
      logic seen;
      seen   = 1'b0;
      keep_d = '0;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         if (act_data_d[4*k +: 4] != 4'h0) begin
            seen = 1'b1;
         end
         keep_d[k] = seen | act_dp_d[k] | (k == 0);
      end
   end

   // The blanking mask only changes when the active buffer changes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         keep_q <= DIGITS'(1);
      end else if (act_upd) begin
         keep_q <= keep_d;
      end
   end

   assign vis = keep_q;
`else
   assign vis = '1;
`endif

   // Output values for the current index and count; they are registered below
   always_comb begin
      nib_d   = act_nib[idx_q];
      dp_d    = act_dp_q[idx_q];
      sel_n_d = '1;
      if (run && (cnt_q >= CW'(BLANK)) && act_en_q[idx_q] && vis[idx_q]) begin
         sel_n_d[idx_q] = 1'b0;
      end
      fd_d    = wrap;
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q        <= '0;
         idx_q        <= '0;
         pend_data_q  <= '0;
         pend_dp_q    <= '0;
         pend_en_q    <= '0;
         pend_valid_q <= 1'b0;
         act_data_q   <= '0;
         act_dp_q     <= '0;
         act_en_q     <= '0;
         nib_q        <= '0;
         dp_q         <= 1'b0;
         sel_n_q      <= '1;
         fd_q         <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         pend_data_q  <= pend_data_d;
         pend_dp_q    <= pend_dp_d;
         pend_en_q    <= pend_en_d;
         pend_valid_q <= pend_valid_d;
         act_data_q   <= act_data_d;
         act_dp_q     <= act_dp_d;
         act_en_q     <= act_en_d;
         nib_q        <= nib_d;
         dp_q         <= dp_d;
         sel_n_q      <= sel_n_d;
         fd_q         <= fd_d;
      end
   end

   assign nib_out    = nib_q;
   assign dp_out     = dp_q;
   assign dig_sel_n  = sel_n_q;
   assign frame_done = fd_q;

endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
- Time-multiplexes DIGITS hex characters through a single shared 7-segment decoder.
- Drives the decoder's nibble and dp inputs and a one-hot, active-low digit-select bus.
- Double-buffers host data so a display update never tears mid-frame.
- Sits between the register/host logic and the decoder + anode drivers on the board.

Parameters:
DIGITS, 4, number of multiplexed digits (2..8)
PRESCALE, 1000, clock cycles per digit slot (>= BLANK+2)
BLANK, 16, cycles at the start of each slot with all digits off (anti-ghosting, 0..PRESCALE-2)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
run  input  1  1 = scanning active; 0 = freeze scan, all digits off
load  input  1  one-cycle strobe; capture data_in/dp_in/en_in
data_in  input  4*DIGITS  hex value per digit; digit k = bits [4k+3:4k]
dp_in  input  DIGITS  decimal-point per digit
en_in  input  DIGITS  digit enable mask; 0 = digit always dark
nib_out  output  4  nibble to decoder
dp_out  output  1  dp to decoder
dig_sel_n  output  DIGITS  active-low one-hot digit select
frame_done  output  1  one-cycle pulse at frame wrap

Behaviour:
- Reset (async, rst_n=0):
  - prescaler=0, index=0, pending_valid=0.
  - active and pending buffers all 0.
  - dig_sel_n all ones, nib_out=0, dp_out=0, frame_done=0.
- Prescaler:
  - counts 0..PRESCALE-1 while run=1.
  - slot tick when count==PRESCALE-1; count returns to 0.
  - run=0: count and index hold; dig_sel_n forced all ones on the next edge.
- Index:
  - advances by 1 on tick; DIGITS-1 -> 0 is the frame wrap.
  - frame_done=1 for exactly the cycle after the wrap edge.
- Buffering:
  - load=1 writes data_in/dp_in/en_in into pending and sets pending_valid.
  - On a wrap edge with pending_valid=1: active<=pending, pending_valid<=0.
  - load on the same cycle as a wrap: the loaded values go directly to active; pending_valid is cleared.
  - Multiple loads within one frame: last one wins.
  - Never copy pending to active mid-frame.
- Outputs (all registered; reflect the current index/count with 1-cycle latency):
  - nib_out = active data[index]; dp_out = active dp[index].
  - dig_sel_n[index]=0 only when run=1, count>=BLANK and active en[index]=1; every other bit is 1.
  - A disabled digit still consumes its slot, so timing is uniform.
- Frame period: DIGITS*PRESCALE cycles.
- Reset mid-frame: immediate return to reset values; scanning restarts at digit 0 after release.

Optional Feature:
- Macro: DISPLAY_SCAN_LZB_EN (leading-zero blanking).
- Defined:
  - Digits above the most significant nonzero active digit show dig_sel_n=1 even if enabled.
  - Digit 0 always displays.
  - A digit whose dp bit is set is never blanked.
  - Blanking mask is recomputed only when active changes.
- Undefined: no blanking logic; zeros display normally.

Test Plan:
- Reset/scan: DIGITS=4, PRESCALE=4, BLANK=1, en=1111, run=1 after reset.
  - dig_sel_n sequence 1111, 1110 x3, 1111, 1101 x3, ... per slot.
  - frame_done pulses every 16 cycles.
- Buffering: load data_in=16'h1234 mid-frame.
  - nib_out keeps the old values until the wrap, then shows 4,3,2,1 on digits 0..3.
  - load on the exact wrap cycle is used in that frame.
- Enable mask: en_in=0101.
  - dig_sel_n bits 1 and 3 stay 1 throughout.
  - nib_out still steps through all four slots.
- run toggle: run=0 mid-slot for 10 cycles.
  - dig_sel_n=1111 the next cycle; count/index frozen.
  - Resumes at the same count when run=1.
- Async reset: assert rst_n=0 at index 2, between clock edges.
  - Outputs reach reset values immediately (no clock edge needed).
  - active buffer reads 0.
- LZB (macro defined): data=16'h0050, dp=0000.
  - Digits 3 and 2 dark; 5 and 0 displayed.
  - dp=1000: digit 3 shows 0 with dp.
